// File: rtl/delta_codec_pkg.sv
// Shared definitions for the delta-coded link receive side.
// Holds the default frame geometry, the decoder state encoding and the
// helper that locates a lane inside a flattened frame vector.
package delta_codec_pkg;

  localparam int N_DEF  = 9;  // lanes per frame
  localparam int W_DEF  = 8;  // lane width in bits
  localparam int CW_DEF = 4;  // count width, 2^CW > N

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } dec_state_t;

  // Low bit of lane k in a flattened vector of w-bit lanes.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/delta_mono_check.sv
// Frame integrity checker for the delta decoder.
// Flags a lane inside the meaningful range whose delta is zero (a duplicate
// of the previous value, lane 0 excluded since it is absolute) or whose
// addition to the running accumulator carries out of the lane width
// (the reconstructed sequence would not be increasing).
// Ports:
//   idx       lane currently being accumulated
//   count     number of meaningful lanes in the frame
//   acc       running sum before this lane
//   delta     delta for this lane
//   violation high when this lane breaks monotonicity
module delta_mono_check #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic [CW-1:0] idx,
  input  logic [CW-1:0] count,
  input  logic [W-1:0]  acc,
  input  logic [W-1:0]  delta,
  output logic          violation
);

  logic [W-1:0] sum;
  logic         carry;
  logic         in_frame;
  logic         dup;

  assign sum      = acc + delta;
  // A modular sum smaller than its operand means the true sum wrapped.
  assign carry    = (sum < acc);
  assign in_frame = (idx < count);
  assign dup      = (idx != '0) && (delta == '0);

  assign violation = in_frame && (dup || carry);

endmodule

// File: rtl/delta_reconstruct_decoder.sv
// Delta reconstruct decoder.
// Rebuilds sorted unique values from a frame of delta-coded lanes by a
// running prefix sum, one lane per cycle. Lanes at or beyond the (clamped)
// unique count are forced to zero. Valid/ready handshake on both sides.
// Optional macro: DELTA_MONO_CHECK_EN enables the sticky err flag driven by
// delta_mono_check; when undefined err is constant 0.
// Ports:
//   clk, rst     clock (rising edge) and async active-high reset
//   in_valid     frame present on deltas_in/count_in
//   in_ready     decoder idle and able to take a frame
//   deltas_in    N lanes; lane 0 absolute, lanes 1..N-1 differences
//   count_in     unique count for the frame
//   out_valid    reconstructed frame available
//   out_ready    downstream takes the frame
//   values_out   reconstructed lanes
//   count_out    count clamped to N
//   err          integrity flag, meaningful with out_valid
module delta_reconstruct_decoder
  import delta_codec_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*W-1:0] deltas_in,
  input  logic [CW-1:0] count_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N*W-1:0] values_out,
  output logic [CW-1:0] count_out,
  output logic          err
);

  localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(N);

  dec_state_t state_q, state_d;

  logic [W-1:0]  deltas_q [N];
  logic [W-1:0]  lanes_q  [N];
  logic [W-1:0]  acc_q;
  logic [W-1:0]  acc_sum;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_clamped;
  logic          accept;

  assign accept        = in_valid && (state_q == IDLE);
  assign count_clamped = (count_in > COUNT_MAX) ? COUNT_MAX : count_in;
  assign acc_sum       = acc_q + deltas_q[idx_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ACCUM;
      end
      ACCUM: begin
        if (idx_q == IDX_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      for (int k = 0; k < N; k++) begin
        deltas_q[k] <= '0;
        lanes_q[k]  <= '0;
      end
    end else if (accept) begin
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= count_clamped;
      for (int k = 0; k < N; k++) begin
        deltas_q[k] <= deltas_in[lane_lo(k, W) +: W];
        lanes_q[k]  <= '0;
      end
    end else if (state_q == ACCUM) begin
      // Accumulator keeps running past count; only the lane write is masked.
      acc_q          <= acc_sum;
      lanes_q[idx_q] <= (idx_q < count_q) ? acc_sum : '0;
      idx_q          <= idx_q + 1'b1;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign values_out[lane_lo(k, W) +: W] = lanes_q[k];
  end

  assign count_out = count_q;

`ifdef DELTA_MONO_CHECK_EN
  logic viol;
  logic err_q;

  delta_mono_check #(
    .W  (W),
    .CW (CW)
  ) u_mono_check (
    .idx       (idx_q),
    .count     (count_q),
    .acc       (acc_q),
    .delta     (deltas_q[idx_q]),
    .violation (viol)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_q <= 1'b0;
    else if (accept)                       err_q <= 1'b0;
    else if ((state_q == ACCUM) && viol)   err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_delta_reconstruct_decoder.sv
module tb_delta_reconstruct_decoder;
  localparam int N  = 9;
  localparam int W  = 8;
  localparam int CW = 4;
`ifdef DELTA_MONO_CHECK_EN
  localparam logic MONO = 1'b1;
`else
  localparam logic MONO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N*W-1:0] deltas_in = '0;
  logic [CW-1:0] count_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N*W-1:0] values_out;
  logic [CW-1:0] count_out;
  logic          err;

  int checks = 0;
  int failures = 0;

  delta_reconstruct_decoder #(.N(N), .W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .deltas_in  (deltas_in),
    .count_in   (count_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .values_out (values_out),
    .count_out  (count_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input logic [7:0] v0, v1, v2, v3, v4, v5, v6, v7, v8);
    return {v8, v7, v6, v5, v4, v3, v2, v1, v0};
  endfunction

  // Waits for out_valid after an accepting edge and checks latency and frame.
  task automatic wait_out(input string tag, input logic [N*W-1:0] exp_vals,
                          input logic [CW-1:0] exp_cnt, input logic exp_err);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) got = 1;
    end
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_values"}, values_out, exp_vals);
    chk({tag, "_count"}, count_out, exp_cnt);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_in_ready_busy"}, in_ready, 1'b0);
  endtask

  task automatic send(input logic [N*W-1:0] d, input logic [CW-1:0] c);
    @(negedge clk);
    chk("send_in_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    deltas_in = d;
    count_in  = c;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic release_ok(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid_drop"}, out_valid, 1'b0);
  endtask

  logic [N*W-1:0] f1_d, f1_v, f2_d, f3_d, f3_v, f4_d, f4_v;

  initial begin
    f1_d = pk(1, 1, 1, 2, 2, 2, 247, 0, 0);
    f1_v = pk(1, 2, 3, 5, 7, 9, 0, 0, 0);
    f2_d = pk(7, 3, 0, 200, 9, 1, 1, 4, 255);
    f3_d = pk(10, 1, 1, 1, 1, 1, 1, 1, 1);
    f3_v = pk(10, 11, 12, 13, 14, 15, 16, 17, 18);
    f4_d = pk(250, 10, 0, 5, 5, 5, 5, 5, 5);
    f4_v = pk(250, 4, 4, 0, 0, 0, 0, 0, 0);

    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_values", values_out, '0);
    chk("rst_count", count_out, '0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    send(f1_d, 4'd6);
    wait_out("enc_frame", f1_v, 4'd6, 1'b0);
    release_ok("enc_frame");

    send(f2_d, 4'd0);
    wait_out("count0", '0, 4'd0, 1'b0);
    release_ok("count0");

    send(f3_d, 4'd12);
    wait_out("clamp", f3_v, 4'd9, 1'b0);
    release_ok("clamp");

    // Stall in DONE with a second frame already offered.
    out_ready = 1'b0;
    send(f1_d, 4'd6);
    wait_out("stall", f1_v, 4'd6, 1'b0);
    in_valid  = 1'b1;
    deltas_in = f3_d;
    count_in  = 4'd12;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_values", values_out, f1_v);
      chk("stall_count", count_out, 4'd6);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("handshake_out_valid", out_valid, 1'b0);
    chk("handshake_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out("second", f3_v, 4'd9, 1'b0);
    release_ok("second");

    // Reset during the fourth ACCUM cycle.
    @(negedge clk);
    in_valid  = 1'b1;
    deltas_in = f1_d;
    count_in  = 4'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_values", values_out, '0);
    chk("midrst_count", count_out, '0);
    chk("midrst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    send(f3_d, 4'd12);
    wait_out("after_rst", f3_v, 4'd9, 1'b0);
    release_ok("after_rst");

    send(f4_d, 4'd3);
    wait_out("mono", f4_v, 4'd3, MONO);
    release_ok("mono");

    // Clean frame after a flagged one: err must clear on accept.
    send(f1_d, 4'd6);
    wait_out("err_clear", f1_v, 4'd6, 1'b0);
    release_ok("err_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
